ram_rmw_ctrl: RTL



---
 rtl/ram_rmw_ctrl_pkg.sv | 17 +
 rtl/ram_rmw_ctrl_rmw_alu.sv | 27 ++
 rtl/ram_rmw_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/ram_rmw_ctrl_pkg.sv
// Shared encodings for the read-modify-write controller: request opcodes and
// controller states.
package ram_rmw_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_READ = 2'd0,
        OP_SET  = 2'd1,
        OP_ADD  = 2'd2,
        OP_RSVD = 2'd3
    } op_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/ram_rmw_ctrl_rmw_alu.sv
// Combinational update unit: computes the post-operation word from the old
// word, the request operand and the opcode.
module rmw_alu
    import ram_rmw_ctrl_pkg::*;
#(
    parameter int W = 32
) (
    input  op_e          op_i,
    input  logic [W-1:0] old_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] new_o
);

    logic [W:0] sum;

    always_comb begin
        sum   = {1'b0, old_i} + {1'b0, data_i};
        new_o = old_i;
        case (op_i)
            OP_SET:  new_o = data_i;
            // The carry-out bit flags overflow; clamp to all ones.
            OP_ADD:  new_o = sum[W] ? {W{1'b1}} : sum[W-1:0];
            default: new_o = old_i;
        endcase
    end

endmodule

// File: rtl/ram_rmw_ctrl.sv
// Read-modify-write front end for a true dual-port RAM: zero-sweeps the RAM
// after reset, then reads on port A, updates, and writes back on port B.
module ram_rmw_ctrl
    import ram_rmw_ctrl_pkg::*;
#(
    parameter int RAM_DEPTH      = 16,
    parameter int RAM_ADDR_WIDTH = 4,
    parameter int RAM_DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_val,
    output logic                      req_rdy,
    input  logic [1:0]                req_op,
    input  logic [RAM_ADDR_WIDTH-1:0] req_addr,
    input  logic [RAM_DATA_WIDTH-1:0] req_data,
    output logic                      resp_val,
    output logic [RAM_ADDR_WIDTH-1:0] resp_addr,
    output logic [RAM_DATA_WIDTH-1:0] resp_old,
    output logic [RAM_DATA_WIDTH-1:0] resp_new,
    output logic                      init_done,
    output logic                      ram_ena,
    output logic                      ram_wea,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addra,
    output logic [RAM_DATA_WIDTH-1:0] ram_dina,
    input  logic [RAM_DATA_WIDTH-1:0] ram_douta,
    output logic                      ram_enb,
    output logic                      ram_web,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addrb,
    output logic [RAM_DATA_WIDTH-1:0] ram_dinb
);

    localparam logic [RAM_ADDR_WIDTH-1:0] LAST_ADDR = RAM_ADDR_WIDTH'(RAM_DEPTH - 1);

    state_e                      state_q, state_d;
    logic [RAM_ADDR_WIDTH-1:0]   init_cnt_q, init_cnt_d;

    logic                        s1_val_q;
    op_e                         s1_op_q;
    logic [RAM_ADDR_WIDTH-1:0]   s1_addr_q;
    logic [RAM_DATA_WIDTH-1:0]   s1_data_q;

    logic                        lw_val_q;
    logic [RAM_ADDR_WIDTH-1:0]   lw_addr_q;
    logic [RAM_DATA_WIDTH-1:0]   lw_data_q;

    logic                        resp_val_q;
    logic [RAM_ADDR_WIDTH-1:0]   resp_addr_q;
    logic [RAM_DATA_WIDTH-1:0]   resp_old_q, resp_new_q;

    logic                        accept, sweep_wr, s1_wr, bypass;
    logic [RAM_DATA_WIDTH-1:0]   old_val, new_val;

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        if (state_q == ST_INIT) begin
            if (init_cnt_q == LAST_ADDR) begin
                state_d = ST_RUN;
            end else begin
                init_cnt_d = init_cnt_q + 1'b1;
            end
        end
    end

    // Port B is idle while reset is held so no write lands before the sweep starts.
    assign sweep_wr  = (state_q == ST_INIT) && rst_n;
    assign req_rdy   = (state_q == ST_RUN);
    assign init_done = (state_q == ST_RUN);
    assign accept    = req_val && req_rdy;

    assign ram_ena   = accept;
    assign ram_wea   = 1'b0;
    assign ram_addra = accept ? req_addr : '0;
    assign ram_dina  = '0;

    // The RAM returns stale data for a same-cycle read/write; forward the last write.
    assign bypass  = lw_val_q && (lw_addr_q == s1_addr_q);
    assign old_val = bypass ? lw_data_q : ram_douta;
    assign s1_wr   = s1_val_q && ((s1_op_q == OP_SET) || (s1_op_q == OP_ADD));

    rmw_alu #(
        .W (RAM_DATA_WIDTH)
    ) u_alu (
        .op_i   (s1_op_q),
        .old_i  (old_val),
        .data_i (s1_data_q),
        .new_o  (new_val)
    );

    assign ram_enb   = sweep_wr || s1_wr;
    assign ram_web   = sweep_wr || s1_wr;
    assign ram_addrb = sweep_wr ? init_cnt_q : (s1_wr ? s1_addr_q : '0);
    assign ram_dinb  = s1_wr ? new_val : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            s1_val_q    <= 1'b0;
            s1_op_q     <= OP_READ;
            s1_addr_q   <= '0;
            s1_data_q   <= '0;
            lw_val_q    <= 1'b0;
            lw_addr_q   <= '0;
            lw_data_q   <= '0;
            resp_val_q  <= 1'b0;
            resp_addr_q <= '0;
            resp_old_q  <= '0;
            resp_new_q  <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            s1_val_q   <= accept;
            s1_op_q    <= op_e'(req_op);
            s1_addr_q  <= req_addr;
            s1_data_q  <= req_data;
            lw_val_q   <= s1_wr;
            if (s1_wr) begin
                lw_addr_q <= s1_addr_q;
                lw_data_q <= new_val;
            end
            resp_val_q <= s1_val_q;
            if (s1_val_q) begin
                resp_addr_q <= s1_addr_q;
                resp_old_q  <= old_val;
                resp_new_q  <= new_val;
            end
        end
    end

    assign resp_val  = resp_val_q;
    assign resp_addr = resp_addr_q;
    assign resp_old  = resp_old_q;
    assign resp_new  = resp_new_q;

endmodule
